// File: rtl/ikaopll_pg_multi.sv
// Time-multiplexed OPLL phase generator: per-slot increment, accumulator
// memory and a free-running noise LFSR.
module ikaopll_pg_multi #(
  parameter int SLOTS   = 18,
  parameter int FNUM_W  = 9,
  parameter int PHASE_W = 19,
  parameter int OUT_W   = 10
) (
  input  logic                     i_EMUCLK,
  input  logic                     i_IC,
  input  logic                     i_CEN_n,
  input  logic                     i_SLOT_SYNC,
  input  logic [FNUM_W-1:0]        i_FNUM,
  input  logic [2:0]               i_BLOCK,
  input  logic [3:0]               i_MUL,
  input  logic                     i_PM,
  input  logic [2:0]               i_PMVAL,
  input  logic                     i_PHASE_RST,
  input  logic                     i_TEST_HOLD,
  output logic [$clog2(SLOTS)-1:0] o_SLOT,
  output logic [OUT_W-1:0]         o_PHASE,
  output logic                     o_VALID,
  output logic                     o_NOISE
);

  localparam int SW  = $clog2(SLOTS);
  localparam int FW  = FNUM_W + 2;
  localparam int SHW = FNUM_W + 8;
  localparam int PRW = SHW + 5;

  logic cen;
  assign cen = ~i_CEN_n;

  logic [SW-1:0]     slot_cnt;

  logic [SW-1:0]     s1_slot;
  logic [FNUM_W-1:0] s1_fnum;
  logic [2:0]        s1_block;
  logic [3:0]        s1_mul;
  logic              s1_pm;
  logic [2:0]        s1_pmval;
  logic              s1_prst;

  logic [SW-1:0]      s2_slot;
  logic [PHASE_W-1:0] s2_inc;
  logic               s2_prst;

  logic [SW-1:0]    s3_slot;
  logic [OUT_W-1:0] s3_phase;

  logic [2:0]  vld;
  logic [22:0] lfsr;

  logic [PHASE_W-1:0] acc [SLOTS];

  logic [2:0]         mag;
  logic [FW-1:0]      fpm;
  logic [SHW:0]       shl;
  logic [SHW-1:0]     blk;
  logic [4:0]         mul2;
  logic [PRW-1:0]     prod;
  logic [PHASE_W-1:0] inc;
  logic [PHASE_W-1:0] acc_cur;
  logic [PHASE_W-1:0] acc_nxt;

  // Vibrato depth comes from the top three F-number bits.
  always_comb begin
    mag = 3'd0;
    if (s1_pm) begin
      case (s1_pmval[1:0])
        2'b01, 2'b11: mag = {1'b0, s1_fnum[FNUM_W-1 -: 2]};
        2'b10:        mag = s1_fnum[FNUM_W-1 -: 3];
        default:      mag = 3'd0;
      endcase
    end
    fpm = {1'b0, s1_fnum, 1'b0};
    if (s1_pm && s1_pmval[2])
      fpm = fpm - FW'(mag);
    else
      fpm = fpm + FW'(mag);
    shl = (SHW+1)'(fpm) << s1_block;
    blk = SHW'(shl >> 1);
  end

  always_comb begin
    mul2 = 5'd1;
    case (s1_mul)
      4'd0:  mul2 = 5'd1;
      4'd1:  mul2 = 5'd2;
      4'd2:  mul2 = 5'd4;
      4'd3:  mul2 = 5'd6;
      4'd4:  mul2 = 5'd8;
      4'd5:  mul2 = 5'd10;
      4'd6:  mul2 = 5'd12;
      4'd7:  mul2 = 5'd14;
      4'd8:  mul2 = 5'd16;
      4'd9:  mul2 = 5'd18;
      4'd10: mul2 = 5'd20;
      4'd11: mul2 = 5'd20;
      4'd12: mul2 = 5'd24;
      4'd13: mul2 = 5'd24;
      4'd14: mul2 = 5'd30;
      4'd15: mul2 = 5'd30;
      default: mul2 = 5'd1;
    endcase
    prod = PRW'(blk) * PRW'(mul2);
    inc  = PHASE_W'(prod >> 1);
  end

  // Phase restart wins over the test-mode freeze.
  always_comb begin
    acc_cur = acc[s2_slot];
    if (s2_prst)
      acc_nxt = s2_inc;
    else if (i_TEST_HOLD)
      acc_nxt = acc_cur;
    else
      acc_nxt = acc_cur + s2_inc;
  end

  always_ff @(posedge i_EMUCLK or posedge i_IC) begin
    if (i_IC) begin
      slot_cnt <= '0;
      s1_slot  <= '0;
      s1_fnum  <= '0;
      s1_block <= '0;
      s1_mul   <= '0;
      s1_pm    <= 1'b0;
      s1_pmval <= '0;
      s1_prst  <= 1'b0;
      s2_slot  <= '0;
      s2_inc   <= '0;
      s2_prst  <= 1'b0;
      s3_slot  <= '0;
      s3_phase <= '0;
      vld      <= '0;
      o_SLOT   <= '0;
      o_PHASE  <= '0;
      o_VALID  <= 1'b0;
    end else if (cen) begin
      if (i_SLOT_SYNC || slot_cnt == SW'(SLOTS-1))
        slot_cnt <= '0;
      else
        slot_cnt <= slot_cnt + SW'(1);
      s1_slot  <= slot_cnt;
      s1_fnum  <= i_FNUM;
      s1_block <= i_BLOCK;
      s1_mul   <= i_MUL;
      s1_pm    <= i_PM;
      s1_pmval <= i_PMVAL;
      s1_prst  <= i_PHASE_RST;
      s2_slot  <= s1_slot;
      s2_inc   <= inc;
      s2_prst  <= s1_prst;
      s3_slot  <= s2_slot;
      s3_phase <= acc_nxt[PHASE_W-1 -: OUT_W];
      vld      <= {vld[1:0], 1'b1};
      o_SLOT   <= s3_slot;
      o_PHASE  <= s3_phase;
      o_VALID  <= vld[2];
    end
  end

  always_ff @(posedge i_EMUCLK or posedge i_IC) begin
    if (i_IC) begin
      for (int i = 0; i < SLOTS; i++)
        acc[i] <= '0;
    end else if (cen) begin
      acc[s2_slot] <= acc_nxt;
    end
  end

  always_ff @(posedge i_EMUCLK or posedge i_IC) begin
    if (i_IC)
      lfsr <= '0;
    else if (cen)
      lfsr <= (lfsr == '0) ? 23'd1 : {lfsr[21:0], lfsr[22] ^ lfsr[8]};
  end

  assign o_NOISE = lfsr[22];

endmodule
